// File: rtl/cpu_pkg.sv
// Shared types for the memory-port arbiter: response owner tags and fixed latencies.
package cpu_pkg;

  typedef enum logic [2:0] {NONE, FETCH, FETCH_ERR, LSU, DBG} owner_t;

  localparam int unsigned MEM_LAT  = 1;
  localparam logic [3:0]  WAIT_SAT = 4'd15;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority one-hot select (index 0 highest); urgent requesters form a higher tier
// that is searched first, in the same index order.
module arb_prio_sel #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] urgent,
  output logic [N-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && urgent[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port block RAM between fetch and LSU, tagging reads for 1-cycle return.
// Optional highest-priority debug requester enabled by defining MEM_ARB_DEBUG_PORT_EN.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_flush,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_strb,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
`ifdef MEM_ARB_DEBUG_PORT_EN
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [3:0]        dbg_strb,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
`endif
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

`ifdef MEM_ARB_DEBUG_PORT_EN
  localparam int unsigned NReq     = 3;
  localparam int unsigned DbgIdx   = 0;
  localparam int unsigned LsuIdx   = 1;
  localparam int unsigned FetchIdx = 2;
`else
  localparam int unsigned NReq     = 2;
  localparam int unsigned LsuIdx   = 0;
  localparam int unsigned FetchIdx = 1;
`endif

  logic [NReq-1:0] req_vec, urg_vec, gnt_vec;
  logic [3:0]      wait_q, wait_d;
  owner_t          owner_q, owner_d;
  logic            ferr_q, ferr_d;
  logic            f_live, f_mis, f_starve, f_port_gnt, f_kill;

  assign f_live   = f_req && !c_flush && !rst;
  assign f_mis    = (f_addr[1:0] != 2'b00);
  assign f_starve = f_req && (wait_q >= MaxWait);

  // Misaligned fetches never touch the RAM, so they bypass arbitration entirely.
  always_comb begin
    req_vec           = '0;
    urg_vec           = '0;
    req_vec[FetchIdx] = f_live && !f_mis;
    urg_vec[FetchIdx] = f_starve;
    req_vec[LsuIdx]   = d_req && !rst;
`ifdef MEM_ARB_DEBUG_PORT_EN
    req_vec[DbgIdx]   = dbg_req && !rst;
    urg_vec[DbgIdx]   = 1'b1;
`endif
  end

  arb_prio_sel #(
    .N(NReq)
  ) u_sel (
    .req    (req_vec),
    .urgent (urg_vec),
    .gnt    (gnt_vec)
  );

  assign f_port_gnt = gnt_vec[FetchIdx];
  assign f_gnt      = f_port_gnt || (f_live && f_mis);
  assign d_gnt      = gnt_vec[LsuIdx];
`ifdef MEM_ARB_DEBUG_PORT_EN
  assign dbg_gnt    = gnt_vec[DbgIdx];
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = NONE;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_we    = d_we ? d_strb : 4'b0;
      mem_wdata = d_wdata;
      owner_d   = d_we ? NONE : LSU;
    end else if (f_port_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = f_addr[ADDR_W+1:2];
      owner_d   = FETCH;
    end
`ifdef MEM_ARB_DEBUG_PORT_EN
    if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = dbg_addr[ADDR_W+1:2];
      mem_we    = dbg_we ? dbg_strb : 4'b0;
      mem_wdata = dbg_wdata;
      owner_d   = dbg_we ? NONE : DBG;
    end
`endif
  end

  always_comb begin
    ferr_d = f_live && f_mis;
    if (!f_req || f_gnt) begin
      wait_d = 4'd0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= NONE;
      ferr_q  <= 1'b0;
      wait_q  <= 4'd0;
    end else begin
      owner_q <= owner_d;
      ferr_q  <= ferr_d;
      wait_q  <= wait_d;
    end
  end

  // A flush in the response cycle drops the fetch response that is returning.
  always_comb begin
    f_kill   = c_flush;
    f_rvalid = !rst && !f_kill && ((owner_q == FETCH) || ferr_q);
    f_err    = !rst && !f_kill && ferr_q;
    f_rdata  = (!rst && !f_kill && (owner_q == FETCH)) ? mem_rdata : 32'd0;
    d_rvalid = !rst && (owner_q == LSU);
    d_rdata  = d_rvalid ? mem_rdata : 32'd0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    dbg_rvalid = !rst && (owner_q == DBG);
    dbg_rdata  = dbg_rvalid ? mem_rdata : 32'd0;
`endif
  end

  logic unused_addr;
`ifdef MEM_ARB_DEBUG_PORT_EN
  assign unused_addr = ^{f_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2], d_addr[1:0],
                         dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};
`else
  assign unused_addr = ^{f_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2], d_addr[1:0]};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected read data queued at grant, checked on rvalid.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst, c_flush;
  logic              f_req, f_gnt, f_rvalid, f_err;
  logic [31:0]       f_addr, f_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic [3:0]        d_strb;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  int vec  = 0;
  int errs = 0;
  logic [31:0] exp_f[$];
  logic [31:0] exp_d[$];
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c_flush   (c_flush),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_strb    (d_strb),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Block RAM with 1-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic idle();
    c_flush = 1'b0; f_req = 1'b0; f_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_strb = 4'd0; d_wdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    f_req = 1'b1; f_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    next_cycle(); next_cycle();
    #1;
    vec++;
    if ({f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid, f_err, mem_we} !== 10'd0 ||
        mem_addr !== '0 || f_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      errs++;
      $display("FAIL reset_outputs: got gnt=%b%b en=%b rv=%b%b err=%b we=%b addr=%h, want all 0",
               f_gnt, d_gnt, mem_en, f_rvalid, d_rvalid, f_err, mem_we, mem_addr);
    end
    idle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    vec++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_resp: got rv f=%b d=%b want 0 0", f_rvalid, d_rvalid);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    f_req = 1'b1; f_addr = 32'h100;
    #1;
    vec++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 14'h40 ||
        mem_we !== 4'b0) begin
      errs++;
      $display("FAIL fetch_grant: got f_gnt=%b d_gnt=%b en=%b addr=%h we=%b want 1 0 1 040 0000",
               f_gnt, d_gnt, mem_en, mem_addr, mem_we);
    end
    exp_f.push_back(32'hDEADBEEF);
    next_cycle();
    idle();
    e = exp_f.pop_front();
    vec++;
    if (f_rvalid !== 1'b1 || f_err !== 1'b0 || f_rdata !== e || d_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL fetch_resp: got rv=%b err=%b data=%h d_rv=%b want 1 0 %h 0",
               f_rvalid, f_err, f_rdata, d_rvalid, e);
    end
  endtask

  task automatic test_starvation();
    logic [5:0]  fpat = 6'b010000;
    logic [31:0] e;
    f_req = 1'b1; f_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      #1;
      vec++;
      if (f_gnt !== fpat[i] || d_gnt !== !fpat[i]) begin
        errs++;
        $display("FAIL starve_grant[%0d]: got f_gnt=%b d_gnt=%b want %b %b",
                 i, f_gnt, d_gnt, fpat[i], !fpat[i]);
      end
      if (fpat[i]) exp_f.push_back(32'h0BADF00D);
      else exp_d.push_back(32'h12345678);
      next_cycle();
      if (i == 5) idle();
      vec++;
      if (fpat[i]) begin
        e = exp_f.pop_front();
        if (f_rvalid !== 1'b1 || f_rdata !== e || d_rvalid !== 1'b0) begin
          errs++;
          $display("FAIL starve_fresp[%0d]: got rv=%b data=%h d_rv=%b want 1 %h 0",
                   i, f_rvalid, f_rdata, d_rvalid, e);
        end
      end else begin
        e = exp_d.pop_front();
        if (d_rvalid !== 1'b1 || d_rdata !== e || f_rvalid !== 1'b0 || f_rdata !== 32'd0) begin
          errs++;
          $display("FAIL starve_dresp[%0d]: got rv=%b data=%h f_rv=%b f_data=%h want 1 %h 0 0",
                   i, d_rvalid, d_rdata, f_rvalid, f_rdata, e);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_strb = 4'b0011; d_wdata = 32'hAABBCCDD;
    #1;
    vec++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 14'hC0 ||
        mem_wdata !== 32'hAABBCCDD) begin
      errs++;
      $display("FAIL write_cycle: got gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 0011 0c0 aabbccdd",
               d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    d_we = 1'b0;
    vec++;
    if (d_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL write_no_resp: got d_rvalid=%b want 0", d_rvalid);
    end
    #1;
    vec++;
    if (d_gnt !== 1'b1 || mem_we !== 4'b0 || mem_addr !== 14'hC0) begin
      errs++;
      $display("FAIL read_cycle: got gnt=%b we=%b addr=%h want 1 0000 0c0", d_gnt, mem_we, mem_addr);
    end
    exp_d.push_back(32'h1122CCDD);
    next_cycle();
    idle();
    e = exp_d.pop_front();
    vec++;
    if (d_rvalid !== 1'b1 || d_rdata !== e) begin
      errs++;
      $display("FAIL read_after_write: got rv=%b data=%h want 1 %h", d_rvalid, d_rdata, e);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] e;
    f_req = 1'b1; f_addr = 32'h102;
    #1;
    vec++;
    if (f_gnt !== 1'b1 || mem_en !== 1'b0) begin
      errs++;
      $display("FAIL misal_alone: got f_gnt=%b mem_en=%b want 1 0", f_gnt, mem_en);
    end
    exp_f.push_back(32'd0);
    next_cycle();
    idle();
    e = exp_f.pop_front();
    vec++;
    if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== e) begin
      errs++;
      $display("FAIL misal_resp: got rv=%b err=%b data=%h want 1 1 %h", f_rvalid, f_err, f_rdata, e);
    end
    f_req = 1'b1; f_addr = 32'h102; d_req = 1'b1; d_addr = 32'h200;
    #1;
    vec++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 14'h80) begin
      errs++;
      $display("FAIL misal_concurrent: got f_gnt=%b d_gnt=%b en=%b addr=%h want 1 1 1 080",
               f_gnt, d_gnt, mem_en, mem_addr);
    end
    exp_f.push_back(32'd0);
    exp_d.push_back(32'h12345678);
    next_cycle();
    idle();
    e = exp_f.pop_front();
    vec++;
    if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== e) begin
      errs++;
      $display("FAIL misal_conc_fresp: got rv=%b err=%b data=%h want 1 1 %h",
               f_rvalid, f_err, f_rdata, e);
    end
    e = exp_d.pop_front();
    vec++;
    if (d_rvalid !== 1'b1 || d_rdata !== e) begin
      errs++;
      $display("FAIL misal_conc_dresp: got rv=%b data=%h want 1 %h", d_rvalid, d_rdata, e);
    end
  endtask

  task automatic test_flush();
    logic [31:0] e;
    f_req = 1'b1; f_addr = 32'h100;
    #1;
    vec++;
    if (f_gnt !== 1'b1) begin
      errs++;
      $display("FAIL flush_pre_grant: got f_gnt=%b want 1", f_gnt);
    end
    next_cycle();
    c_flush = 1'b1; d_req = 1'b1; d_addr = 32'h200;
    #1;
    vec++;
    if (f_rvalid !== 1'b0 || f_rdata !== 32'd0 || f_gnt !== 1'b0 || d_gnt !== 1'b1) begin
      errs++;
      $display("FAIL flush_cycle: got f_rv=%b f_data=%h f_gnt=%b d_gnt=%b want 0 0 0 1",
               f_rvalid, f_rdata, f_gnt, d_gnt);
    end
    exp_d.push_back(32'h12345678);
    next_cycle();
    idle();
    e = exp_d.pop_front();
    vec++;
    if (f_rvalid !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== e) begin
      errs++;
      $display("FAIL flush_after: got f_rv=%b d_rv=%b d_data=%h want 0 1 %h",
               f_rvalid, d_rvalid, d_rdata, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    d_req = 1'b1; d_addr = 32'h200;
    #1;
    vec++;
    if (d_gnt !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_grant: got d_gnt=%b want 1", d_gnt);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    vec++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_in_reset: got d_rv=%b d_gnt=%b en=%b want 0 0 0", d_rvalid, d_gnt, mem_en);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    vec++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_resume: got d_rv=%b d_gnt=%b want 0 1", d_rvalid, d_gnt);
    end
    exp_d.push_back(32'h12345678);
    next_cycle();
    idle();
    e = exp_d.pop_front();
    vec++;
    if (d_rvalid !== 1'b1 || d_rdata !== e) begin
      errs++;
      $display("FAIL rstmid_resp: got rv=%b data=%h want 1 %h", d_rvalid, d_rdata, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h200, 32'h300, 32'h100};
    logic [31:0] datas [3] = '{32'h12345678, 32'h1122CCDD, 32'hDEADBEEF};
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      d_req = (i < 2); d_addr = addrs[i];
      f_req = (i == 2); f_addr = addrs[i];
      #1;
      vec++;
      if (d_gnt !== (i < 2) || f_gnt !== (i == 2) || mem_addr !== addrs[i][ADDR_W+1:2]) begin
        errs++;
        $display("FAIL b2b_grant[%0d]: got d_gnt=%b f_gnt=%b addr=%h", i, d_gnt, f_gnt, mem_addr);
      end
      if (i < 2) exp_d.push_back(datas[i]);
      else exp_f.push_back(datas[i]);
      next_cycle();
      if (i == 2) idle();
      vec++;
      if (i < 2) begin
        e = exp_d.pop_front();
        if (d_rvalid !== 1'b1 || d_rdata !== e) begin
          errs++;
          $display("FAIL b2b_dresp[%0d]: got rv=%b data=%h want 1 %h", i, d_rvalid, d_rdata, e);
        end
      end else begin
        e = exp_f.pop_front();
        if (f_rvalid !== 1'b1 || f_rdata !== e || d_rvalid !== 1'b0) begin
          errs++;
          $display("FAIL b2b_fresp: got rv=%b data=%h d_rv=%b want 1 %h 0",
                   f_rvalid, f_rdata, d_rvalid, e);
        end
      end
    end
  endtask

  initial begin
    ram[14'h40] <= 32'hDEADBEEF;
    ram[14'h41] <= 32'h0BADF00D;
    ram[14'h80] <= 32'h12345678;
    ram[14'hC0] <= 32'h11223344;
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_fetch();
    test_starvation();
    test_write_read();
    test_misaligned();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
